// File: rtl/johnson_counter_param.sv
// johnson_counter_param
// Parametrised Johnson (twisted-ring) / ring counter with up/down stepping,
// parallel load, self-correction of illegal states, a decoded phase index,
// and one-cycle wrap and error pulses.
module johnson_counter_param #(
   parameter  int WIDTH = 4,
   localparam int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    phase,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] RING_RESET = {1'b1, {(WIDTH-1){1'b0}}};
   localparam int               LAST_JOHN  = 2*WIDTH - 1;
   localparam int               LAST_RING  = WIDTH - 1;

   // What the counter does on the coming edge, in priority order
   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_MODE,
      ACT_LOAD,
      ACT_FIX,
      ACT_STEP
   } action_t;

   logic [WIDTH-1:0] r_q;
   logic             r_modeQ;
   logic             r_wrap;
   logic             r_err;

   logic [WIDTH-1:0] w_nextQ;
   logic             w_nextWrap;
   logic             w_nextErr;
   logic             w_qLegal;
   logic             w_loadLegal;
   int               w_curPhase;
   action_t          w_action;

   // Number of set bits in a vector
   function automatic int onesCount(input logic [WIDTH-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < WIDTH; i++) begin
         c += int'(v[i]);
      end
      return c;
   endfunction

   // Johnson legal patterns have at most one 0/1 boundary between adjacent
   // bits; ring legal patterns are one-hot
   function automatic logic isLegal(input logic [WIDTH-1:0] v, input logic ringMode);
      int edges;
      edges = 0;
      if (ringMode) begin
         return (onesCount(v) == 1);
      end
      for (int i = 0; i < WIDTH-1; i++) begin
         edges += int'(v[i] ^ v[i+1]);
      end
      return (edges <= 1);
   endfunction

   // Position of a legal pattern inside its sequence, 0 = mode reset value
   function automatic int phaseOf(input logic [WIDTH-1:0] v, input logic ringMode);
      int n;
      int idx;
      n   = onesCount(v);
      idx = 0;
      if (ringMode) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
               idx = i;
            end
         end
         return WIDTH - 1 - idx;
      end
      if ((v == '0) || v[WIDTH-1]) begin
         return n;
      end
      return 2*WIDTH - n;
   endfunction

   // Starting pattern of a sequence
   function automatic logic [WIDTH-1:0] modeReset(input logic ringMode);
      return ringMode ? RING_RESET : '0;
   endfunction

   // Decode the current state and pick the highest-priority action
   always_comb begin
      w_qLegal    = isLegal(r_q, r_modeQ);
      w_loadLegal = isLegal(load_val, r_modeQ);
      w_curPhase  = phaseOf(r_q, r_modeQ);
      w_action    = ACT_HOLD;
      if (mode != r_modeQ) begin
         w_action = ACT_MODE;
      end else if (load) begin
         w_action = ACT_LOAD;
      end else if (!w_qLegal) begin
         w_action = ACT_FIX;
      end else if (en) begin
         w_action = ACT_STEP;
      end
   end

   // Compute next counter value and the wrap/err pulses for the chosen action
   always_comb begin
      w_nextQ    = r_q;
      w_nextWrap = 1'b0;
      w_nextErr  = 1'b0;
      case (w_action)
         ACT_MODE: begin
            w_nextQ = modeReset(mode);
         end
         ACT_LOAD: begin
            if (w_loadLegal) begin
               w_nextQ = load_val;
            end else begin
               w_nextQ   = modeReset(r_modeQ);
               w_nextErr = 1'b1;
            end
         end
         ACT_FIX: begin
            w_nextQ   = modeReset(r_modeQ);
            w_nextErr = 1'b1;
         end
         ACT_STEP: begin
            if (!dir) begin
               w_nextQ    = r_modeQ ? {r_q[0], r_q[WIDTH-1:1]}
                                    : {~r_q[0], r_q[WIDTH-1:1]};
               w_nextWrap = (w_curPhase == (r_modeQ ? LAST_RING : LAST_JOHN));
            end else begin
               w_nextQ    = r_modeQ ? {r_q[WIDTH-2:0], r_q[WIDTH-1]}
                                    : {r_q[WIDTH-2:0], ~r_q[WIDTH-1]};
               w_nextWrap = (w_curPhase == 0);
            end
         end
         default: begin
            w_nextQ = r_q;
         end
      endcase
   end

   // State, sampled mode and event pulses; reset forces the Johnson start state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q     <= '0;
         r_modeQ <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_q     <= w_nextQ;
         r_modeQ <= mode;
         r_wrap  <= w_nextWrap;
         r_err   <= w_nextErr;
      end
   end

   assign q     = r_q;
   assign phase = PW'(w_curPhase);
   assign wrap  = r_wrap;
   assign err   = r_err;

endmodule
